gcd_req_driver: RTL and testbench

- Initiator/consumer side of the GCD core handshake (start/Ain/Bin in, Out/valid out).
- Accepts operand pairs on a ready/valid request channel and launches one computation on an attached GCD core (fast or slow variant).
- Waits for the core's sticky valid, then returns the result on a ready/valid response channel with an error code and latency count.
- Guards against core hangs: zero-operand pre-check plus a wait timeout that flushes the core.

---
 rtl/gcd_req_driver.sv | 146 ++++++++++++++
 tb/tb_gcd_req_driver.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_req_driver.sv
// Request/response front end for a GCD core. It launches one computation per
// accepted request, waits for the core's sticky valid, and flushes the core on timeout.
module gcd_req_driver #(
  parameter int W       = 3,
  parameter int TIMEOUT = 32,
  parameter int CW      = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [W-1:0]  req_a,
  input  logic [W-1:0]  req_b,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [W-1:0]  resp_gcd,
  output logic [1:0]    resp_err,
  output logic [CW-1:0] resp_cycles,
  output logic          core_start,
  output logic          core_reset,
  output logic [W-1:0]  core_a,
  output logic [W-1:0]  core_b,
  input  logic [W-1:0]  core_out,
  input  logic          core_valid
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and payload holds until the transfer.
  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_FLUSH,
    S_RESP
  } state_t;

  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

  state_t        state_q, state_d;
  logic          req_ready_q, req_ready_d;
  logic          resp_valid_q, resp_valid_d;
  logic [W-1:0]  resp_gcd_q, resp_gcd_d;
  logic [1:0]    resp_err_q, resp_err_d;
  logic [CW-1:0] resp_cycles_q, resp_cycles_d;
  logic          core_start_q, core_start_d;
  logic [W-1:0]  core_a_q, core_a_d;
  logic [W-1:0]  core_b_q, core_b_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;

  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    state_d       = state_q;
    resp_gcd_d    = resp_gcd_q;
    resp_err_d    = resp_err_q;
    resp_cycles_d = resp_cycles_q;
    core_a_d      = core_a_q;
    core_b_d      = core_b_q;
    cnt_d         = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          core_a_d = req_a;
          core_b_d = req_b;
          // A zero operand would hang the core, so answer without starting it.
          if (req_a == '0 || req_b == '0) begin
            state_d       = S_RESP;
            resp_gcd_d    = '0;
            resp_err_d    = 2'b01;
            resp_cycles_d = '0;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_inc;
        // Valid takes priority over a timeout landing in the same cycle.
        if (core_valid) begin
          state_d       = S_RESP;
          resp_gcd_d    = core_out;
          resp_err_d    = 2'b00;
          resp_cycles_d = cnt_inc;
        end else if (cnt_inc == TIMEOUT_C) begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        state_d       = S_RESP;
        resp_gcd_d    = '0;
        resp_err_d    = 2'b10;
        resp_cycles_d = TIMEOUT_C;
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    req_ready_d  = (state_d == S_IDLE);
    resp_valid_d = (state_d == S_RESP);
    core_start_d = (state_d == S_ISSUE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      req_ready_q   <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_gcd_q    <= '0;
      resp_err_q    <= 2'b00;
      resp_cycles_q <= '0;
      core_start_q  <= 1'b0;
      core_a_q      <= '0;
      core_b_q      <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      req_ready_q   <= req_ready_d;
      resp_valid_q  <= resp_valid_d;
      resp_gcd_q    <= resp_gcd_d;
      resp_err_q    <= resp_err_d;
      resp_cycles_q <= resp_cycles_d;
      core_start_q  <= core_start_d;
      core_a_q      <= core_a_d;
      core_b_q      <= core_b_d;
      cnt_q         <= cnt_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_gcd    = resp_gcd_q;
  assign resp_err    = resp_err_q;
  assign resp_cycles = resp_cycles_q;
  assign core_start  = core_start_q;
  assign core_a      = core_a_q;
  assign core_b      = core_b_q;
  // The core's reset is synchronous, so hold it during our async reset too.
  assign core_reset  = !reset_n || (state_q == S_FLUSH);

endmodule

// File: tb/tb_gcd_req_driver.sv
// Bench for gcd_req_driver: one instance on a fast/slow GCD core model, one with
// TIMEOUT=4 on a programmable-latency stub core.
module tb_gcd_req_driver;
  localparam int W  = 3;
  localparam int CW = 8;
  localparam int EW = W + 2 + CW;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  logic          req_valid, req_ready, resp_valid, resp_ready;
  logic [W-1:0]  req_a, req_b, resp_gcd, core_a, core_b, core_out;
  logic [1:0]    resp_err;
  logic [CW-1:0] resp_cycles;
  logic          core_start, core_reset, core_valid;

  logic          req_valid2, req_ready2, resp_valid2, resp_ready2;
  logic [W-1:0]  req_a2, req_b2, resp_gcd2, core_a2, core_b2, core_out2;
  logic [1:0]    resp_err2;
  logic [CW-1:0] resp_cycles2;
  logic          core_start2, core_reset2, core_valid2;

  gcd_req_driver #(.W(W), .TIMEOUT(32), .CW(CW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_gcd(resp_gcd),
    .resp_err(resp_err), .resp_cycles(resp_cycles),
    .core_start(core_start), .core_reset(core_reset), .core_a(core_a), .core_b(core_b),
    .core_out(core_out), .core_valid(core_valid)
  );

  gcd_req_driver #(.W(W), .TIMEOUT(4), .CW(CW)) dut_to (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid2), .req_ready(req_ready2), .req_a(req_a2), .req_b(req_b2),
    .resp_valid(resp_valid2), .resp_ready(resp_ready2), .resp_gcd(resp_gcd2),
    .resp_err(resp_err2), .resp_cycles(resp_cycles2),
    .core_start(core_start2), .core_reset(core_reset2), .core_a(core_a2), .core_b(core_b2),
    .core_out(core_out2), .core_valid(core_valid2)
  );

  // GCD core model: fast variant subtracts once per cycle; slow adds one output stage.
  logic [W-1:0] ca, cb, cout_f, cout_s;
  logic         cv_f, cv_s, slow_sel;
  always @(posedge clk) begin
    if (core_reset) begin
      ca <= '0; cb <= '0; cout_f <= '0; cout_s <= '0; cv_f <= 1'b0; cv_s <= 1'b0;
    end else if (core_start) begin
      ca <= core_a; cb <= core_b; cv_f <= 1'b0; cv_s <= 1'b0;
    end else begin
      if (!cv_f) begin
        if (ca == cb) begin cv_f <= 1'b1; cout_f <= ca; end
        else if (ca > cb) ca <= ca - cb;
        else cb <= cb - ca;
      end
      cv_s   <= cv_f;
      cout_s <= cout_f;
    end
  end
  assign core_out   = slow_sel ? cout_s : cout_f;
  assign core_valid = slow_sel ? cv_s : cv_f;

  // Stub core: valid rises so the driver sees it in WAIT cycle stub_lat (0 = never).
  logic [7:0] stub_lat, scnt;
  logic       sv2;
  always @(posedge clk) begin
    if (core_reset2) begin
      scnt <= '0; sv2 <= 1'b0;
    end else if (core_start2) begin
      scnt <= 8'd1; sv2 <= 1'b0;
    end else if (!sv2 && stub_lat != 0 && scnt != 0) begin
      scnt <= scnt + 8'd1;
      if (scnt + 8'd1 == stub_lat) sv2 <= 1'b1;
    end
  end
  assign core_out2   = 3'd5;
  assign core_valid2 = sv2;

  int tests_run = 0;
  int tests_failed = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp2_q[$];
  logic [EW-1:0] e1, e2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: compare each response handshake against the oldest expectation.
  always @(negedge clk) begin
    if (reset_n && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        tests_run++; tests_failed++;
        $display("FAIL unexpected_resp: got gcd %0d err %0d, expected no response", resp_gcd, resp_err);
      end else begin
        e1 = exp_q.pop_front();
        check("resp_gcd", resp_gcd, e1[EW-1 -: W]);
        check("resp_err", resp_err, e1[CW+1:CW]);
        check("resp_cycles", resp_cycles, e1[CW-1:0]);
        check("req_ready_during_resp", req_ready, 0);
      end
    end
    if (reset_n && resp_valid2 && resp_ready2) begin
      if (exp2_q.size() == 0) begin
        tests_run++; tests_failed++;
        $display("FAIL unexpected_resp2: got gcd %0d err %0d, expected no response", resp_gcd2, resp_err2);
      end else begin
        e2 = exp2_q.pop_front();
        check("resp2_gcd", resp_gcd2, e2[EW-1 -: W]);
        check("resp2_err", resp_err2, e2[CW+1:CW]);
        check("resp2_cycles", resp_cycles2, e2[CW-1:0]);
      end
    end
  end

  int start_cnt = 0;
  logic [W-1:0] start_a, start_b;
  always @(negedge clk) begin
    if (core_start) begin
      start_cnt++;
      start_a = core_a;
      start_b = core_b;
    end
  end

  function automatic void gcd_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] g, output int steps);
    logic [W-1:0] x, y;
    x = a; y = b; steps = 0;
    while (x != y) begin
      if (x > y) x = x - y; else y = y - x;
      steps++;
    end
    g = x;
  endfunction

  // Drivers are entered and leave just after a rising edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    req_a = a; req_b = b; req_valid = 1'b1; n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) begin
      tests_run++; tests_failed++;
      $display("FAIL req_accept: got no req_ready, expected it within 50 cycles");
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic send2(input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    req_a2 = a; req_b2 = b; req_valid2 = 1'b1; n = 0;
    @(negedge clk);
    while (!req_ready2 && n < 50) begin @(negedge clk); n++; end
    if (!req_ready2) begin
      tests_run++; tests_failed++;
      $display("FAIL req2_accept: got no req_ready, expected it within 50 cycles");
    end
    @(posedge clk); #1;
    req_valid2 = 1'b0;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp2_q.size() != 0) && n < 200) begin @(negedge clk); n++; end
    if (exp_q.size() != 0 || exp2_q.size() != 0) begin
      tests_run++; tests_failed++;
      $display("FAIL resp_timeout: got %0d/%0d pending, expected 0", exp_q.size(), exp2_q.size());
      exp_q.delete(); exp2_q.delete();
    end
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [W-1:0]  a, b;
    logic          slow;
    logic [W-1:0]  g;
    logic [1:0]    err;
    logic [CW-1:0] cyc;
  } vec_t;
  vec_t vecs[12];

  initial begin
    int s0, n, steps;
    logic [W-1:0] ra, rb, rg;
    logic rs;
    vecs[0]  = '{3'd6, 3'd4, 1'b0, 3'd2, 2'b00, 8'd4};
    vecs[1]  = '{3'd5, 3'd5, 1'b0, 3'd5, 2'b00, 8'd2};
    vecs[2]  = '{3'd7, 3'd3, 1'b0, 3'd1, 2'b00, 8'd6};
    vecs[3]  = '{3'd1, 3'd7, 1'b0, 3'd1, 2'b00, 8'd8};
    vecs[4]  = '{3'd0, 3'd5, 1'b0, 3'd0, 2'b01, 8'd0};
    vecs[5]  = '{3'd3, 3'd0, 1'b0, 3'd0, 2'b01, 8'd0};
    vecs[6]  = '{3'd6, 3'd3, 1'b0, 3'd3, 2'b00, 8'd3};
    vecs[7]  = '{3'd6, 3'd4, 1'b1, 3'd2, 2'b00, 8'd5};
    vecs[8]  = '{3'd7, 3'd1, 1'b1, 3'd1, 2'b00, 8'd9};
    vecs[9]  = '{3'd4, 3'd6, 1'b1, 3'd2, 2'b00, 8'd5};
    vecs[10] = '{3'd0, 3'd0, 1'b1, 3'd0, 2'b01, 8'd0};
    vecs[11] = '{3'd7, 3'd7, 1'b1, 3'd7, 2'b00, 8'd3};

    // Reset phase
    reset_n = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; resp_ready = 1'b0;
    req_valid2 = 1'b0; req_a2 = '0; req_b2 = '0; resp_ready2 = 1'b1;
    slow_sel = 1'b0; stub_lat = 8'd0;
    #12;
    check("rst_req_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_gcd", resp_gcd, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_resp_cycles", resp_cycles, 0);
    check("rst_core_start", core_start, 0);
    check("rst_core_a", core_a, 0);
    check("rst_core_reset", core_reset, 1);
    check("rst_core_reset2", core_reset2, 1);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("idle_req_ready", req_ready, 1);
    check("idle_core_reset", core_reset, 0);
    resp_ready = 1'b1;

    // Table of vectors
    for (int i = 0; i < 12; i++) begin
      slow_sel = vecs[i].slow;
      exp_q.push_back({vecs[i].g, vecs[i].err, vecs[i].cyc});
      s0 = start_cnt;
      send(vecs[i].a, vecs[i].b);
      wait_empty();
      check("start_pulses", start_cnt - s0, (vecs[i].err == 2'b00) ? 1 : 0);
      if (vecs[i].err == 2'b00) begin
        check("core_a_at_start", start_a, vecs[i].a);
        check("core_b_at_start", start_b, vecs[i].b);
      end
    end

    // Random nonzero pairs against the core model
    for (int i = 0; i < 8; i++) begin
      ra = 3'($urandom_range(1, 7));
      rb = 3'($urandom_range(1, 7));
      rs = 1'($urandom_range(0, 1));
      gcd_model(ra, rb, rg, steps);
      slow_sel = rs;
      exp_q.push_back({rg, 2'b00, 8'(steps + 2 + int'(rs))});
      send(ra, rb);
      wait_empty();
    end

    // Zero operand: no core start, response right after acceptance
    slow_sel = 1'b0;
    s0 = start_cnt;
    exp_q.push_back({3'd0, 2'b01, 8'd0});
    send(3'd0, 3'd5);
    @(negedge clk);
    check("zero_resp_valid", resp_valid, 1);
    wait_empty();
    check("zero_no_start", start_cnt - s0, 0);

    // Held response, second request waiting, stale valid on the next operation
    resp_ready = 1'b0;
    exp_q.push_back({3'd2, 2'b00, 8'd4});
    send(3'd6, 3'd4);
    req_a = 3'd5; req_b = 3'd5; req_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!resp_valid && n < 40) begin @(negedge clk); n++; end
    check("hold_resp_seen", resp_valid, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("hold_resp_valid", resp_valid, 1);
      check("hold_resp_gcd", resp_gcd, 2);
      check("hold_resp_cycles", resp_cycles, 4);
      check("hold_req_ready", req_ready, 0);
    end
    @(posedge clk); #1;
    exp_q.push_back({3'd5, 2'b00, 8'd2});
    resp_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_empty();

    // Reset pulse during WAIT aborts silently
    slow_sel = 1'b1;
    send(3'd7, 3'd1);
    @(negedge clk); @(negedge clk); @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("midrst_req_ready", req_ready, 0);
    check("midrst_resp_valid", resp_valid, 0);
    check("midrst_core_start", core_start, 0);
    check("midrst_core_a", core_a, 0);
    check("midrst_core_reset", core_reset, 1);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    for (int k = 0; k < 15; k++) @(negedge clk);
    check("midrst_no_resp", resp_valid, 0);
    @(posedge clk); #1;
    slow_sel = 1'b0;
    exp_q.push_back({3'd2, 2'b00, 8'd4});
    send(3'd6, 3'd4);
    wait_empty();

    // Timeout on the TIMEOUT=4 instance
    stub_lat = 8'd0;
    exp2_q.push_back({3'd0, 2'b10, 8'd4});
    send2(3'd3, 3'd2);
    @(negedge clk);
    check("to_issue_start", core_start2, 1);
    n = 0;
    do begin @(negedge clk); n++; end while (!core_reset2 && n < 20);
    check("to_wait_len", n, 5);
    @(negedge clk);
    check("to_flush_one_cycle", core_reset2, 0);
    check("to_resp_valid", resp_valid2, 1);
    wait_empty();

    // Valid and timeout in the same cycle: valid wins
    stub_lat = 8'd4;
    exp2_q.push_back({3'd5, 2'b00, 8'd4});
    send2(3'd3, 3'd2);
    wait_empty();
    stub_lat = 8'd2;
    exp2_q.push_back({3'd5, 2'b00, 8'd2});
    send2(3'd1, 3'd6);
    wait_empty();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    tests_run++; tests_failed++;
    $display("FAIL watchdog: got no completion, expected finish before 200000");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
